// File: rtl/riscv_regfile_bist_pkg.sv
// -----------------------------------------------------------------------------
// riscv_regfile_bist_pkg
// Shared definitions for the register-file BIST slice:
//   XLEN          default datapath width (multiple of 8)
//   bist_state_e  FSM state encoding (IDLE/WRITE/READ/DONE)
//   LAST_ADDR     last register index visited in each phase
//   mirror_addr() read-port-2 address partner of the counter value (31 - a)
// Optional feature macro used by the slice: REGFILE_BIST_INV_EN
// -----------------------------------------------------------------------------
package riscv_regfile_bist_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } bist_state_e;

   localparam logic [4:0] LAST_ADDR = 5'd31;

   // rs2 walks the file from the top while rs1 walks from the bottom
   function automatic logic [4:0] mirror_addr(input logic [4:0] a);
      return LAST_ADDR - a;
   endfunction

endpackage

// File: rtl/riscv_regfile_bist_pat.sv
// -----------------------------------------------------------------------------
// riscv_regfile_bist_pat
// Combinational pattern generator for the register-file BIST.
//   P(a) = {XLEN/8{3'b101, a[4:0]}},  D(a) = inv ? ~P(a) : P(a)
//   E(n) = 0 for n == 0 (x0 is hardwired), D(n) otherwise
// Ports:
//   i_a      counter value a
//   i_inv    pass flag (0 = true data, 1 = inverted data)
//   o_d      write data D(a)
//   o_e_rs1  expected read data on rs1, E(a)
//   o_e_rs2  expected read data on rs2, E(31 - a)
// Optional feature macro of this slice: REGFILE_BIST_INV_EN (not used here)
// -----------------------------------------------------------------------------
module riscv_regfile_bist_pat #(
   parameter int XLEN = 32
) (
   input  logic [4:0]      i_a,
   input  logic            i_inv,
   output logic [XLEN-1:0] o_d,
   output logic [XLEN-1:0] o_e_rs1,
   output logic [XLEN-1:0] o_e_rs2
);
   import riscv_regfile_bist_pkg::*;

   logic [4:0]      m_s;
   logic [XLEN-1:0] p_a_s;
   logic [XLEN-1:0] p_m_s;
   logic [XLEN-1:0] d_a_s;
   logic [XLEN-1:0] d_m_s;

   // Build true/inverted patterns for both the counter address and its mirror
   always_comb begin
      m_s   = mirror_addr(i_a);
      p_a_s = {(XLEN/8){3'b101, i_a}};
      p_m_s = {(XLEN/8){3'b101, m_s}};
      if (i_inv) begin
         d_a_s = ~p_a_s;
         d_m_s = ~p_m_s;
      end else begin
         d_a_s = p_a_s;
         d_m_s = p_m_s;
      end
   end

   // x0 always reads back zero whatever was written to it
   always_comb begin
      o_d = d_a_s;
      if (i_a == 5'd0) begin
         o_e_rs1 = {XLEN{1'b0}};
      end else begin
         o_e_rs1 = d_a_s;
      end
      if (m_s == 5'd0) begin
         o_e_rs2 = {XLEN{1'b0}};
      end else begin
         o_e_rs2 = d_m_s;
      end
   end

endmodule

// File: rtl/riscv_regfile_bist.sv
// -----------------------------------------------------------------------------
// riscv_regfile_bist
// March-style BIST for a 32-entry RISC-V integer register file. A start in
// IDLE writes D(a) to every register (WRITE, 32 cycles), then reads the file
// through both read ports, rs1 ascending and rs2 descending (READ, 32 cycles),
// and pulses done for one cycle (DONE). The first mismatch is latched.
// Optional feature macro: REGFILE_BIST_INV_EN -- adds a second WRITE/READ
// pass with inverted data before DONE (128 busy cycles instead of 64).
// Ports:
//   i_clk, i_rstn                  clock, async active-low reset
//   i_bist_start                   start request, sampled only in IDLE
//   o_regfile_rd_addr/_data/_wen   regfile write port
//   o_regfile_rs1_addr/_rs2_addr   regfile read addresses
//   i_regfile_rs1_data/_rs2_data   combinational regfile read data
//   o_bist_busy                    high in WRITE and READ
//   o_bist_done                    one-cycle completion pulse
//   o_bist_fail, o_bist_fail_addr  sticky fail flag, first failing register
// All outputs are registered; they are computed from next-state values so
// that they line up with the state they belong to.
// -----------------------------------------------------------------------------
module riscv_regfile_bist #(
   parameter int XLEN = riscv_regfile_bist_pkg::XLEN
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_bist_start,
   output logic [4:0]      o_regfile_rd_addr,
   output logic [XLEN-1:0] o_regfile_rd_data,
   output logic            o_regfile_rd_wen,
   output logic [4:0]      o_regfile_rs1_addr,
   output logic [4:0]      o_regfile_rs2_addr,
   input  logic [XLEN-1:0] i_regfile_rs1_data,
   input  logic [XLEN-1:0] i_regfile_rs2_data,
   output logic            o_bist_busy,
   output logic            o_bist_done,
   output logic            o_bist_fail,
   output logic [4:0]      o_bist_fail_addr
);
   import riscv_regfile_bist_pkg::*;

   bist_state_e     state_q,     state_d;
   logic [4:0]      a_q,         a_d;
   logic            inv_q,       inv_d;
   logic            wen_q,       wen_d;
   logic [4:0]      rd_addr_q,   rd_addr_d;
   logic [XLEN-1:0] rd_data_q,   rd_data_d;
   logic [4:0]      rs1_addr_q,  rs1_addr_d;
   logic [4:0]      rs2_addr_q,  rs2_addr_d;
   logic            busy_q,      busy_d;
   logic            done_q,      done_d;
   logic            fail_q,      fail_d;
   logic [4:0]      fail_addr_q, fail_addr_d;
   logic [XLEN-1:0] exp_rs1_q,   exp_rs1_d;
   logic [XLEN-1:0] exp_rs2_q,   exp_rs2_d;

   logic [XLEN-1:0] pat_d_s;
   logic [XLEN-1:0] pat_e1_s;
   logic [XLEN-1:0] pat_e2_s;
   logic            rs1_mis_s;
   logic            rs2_mis_s;

   // Patterns are evaluated for the next cycle's address so they can be registered
   riscv_regfile_bist_pat #(.XLEN(XLEN)) u_pat (
      .i_a     (a_d),
      .i_inv   (inv_d),
      .o_d     (pat_d_s),
      .o_e_rs1 (pat_e1_s),
      .o_e_rs2 (pat_e2_s)
   );

   // State register, address counter and pass flag
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         a_q     <= 5'd0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         inv_q   <= inv_d;
      end
   end

   // Next-state, counter and pass sequencing
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      inv_d   = inv_q;
      case (state_q)
         S_IDLE: begin
            if (i_bist_start) begin
               state_d = S_WRITE;
               a_d     = 5'd0;
               inv_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            a_d = a_q + 5'd1;               // 31 wraps to 0 for the READ phase
            if (a_q == LAST_ADDR) begin
               state_d = S_READ;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_READ: begin
            a_d = a_q + 5'd1;
            if (a_q == LAST_ADDR) begin
`ifdef REGFILE_BIST_INV_EN
               if (!inv_q) begin
                  state_d = S_WRITE;        // second pass with inverted data
                  inv_d   = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;               // start is ignored here
         end
         default: begin
            state_d = S_IDLE;
            a_d     = 5'd0;
            inv_d   = 1'b0;
         end
      endcase
`ifndef REGFILE_BIST_INV_EN
      inv_d = 1'b0;
`endif
   end

   assign rs1_mis_s = (i_regfile_rs1_data != exp_rs1_q);
   assign rs2_mis_s = (i_regfile_rs2_data != exp_rs2_q);

   // Output values for the upcoming state plus sticky fail capture
   always_comb begin
      wen_d       = 1'b0;
      rd_addr_d   = 5'd0;
      rd_data_d   = {XLEN{1'b0}};
      rs1_addr_d  = 5'd0;
      rs2_addr_d  = 5'd0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      exp_rs1_d   = pat_e1_s;
      exp_rs2_d   = pat_e2_s;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      case (state_d)
         S_WRITE: begin
            wen_d     = 1'b1;
            rd_addr_d = a_d;
            rd_data_d = pat_d_s;
            busy_d    = 1'b1;
         end
         S_READ: begin
            rs1_addr_d = a_d;
            rs2_addr_d = mirror_addr(a_d);
            busy_d     = 1'b1;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         S_IDLE: begin
            done_d = 1'b0;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
      // Only the first mismatch is recorded; rs1 wins a same-cycle tie
      if ((state_q == S_IDLE) && i_bist_start) begin
         fail_d      = 1'b0;
         fail_addr_d = 5'd0;
      end else if ((state_q == S_READ) && !fail_q) begin
         if (rs1_mis_s) begin
            fail_d      = 1'b1;
            fail_addr_d = a_q;
         end else if (rs2_mis_s) begin
            fail_d      = 1'b1;
            fail_addr_d = mirror_addr(a_q);
         end else begin
            fail_d      = fail_q;
         end
      end else begin
         fail_d = fail_q;
      end
   end

   // Registered outputs and expected-data pipeline
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wen_q       <= 1'b0;
         rd_addr_q   <= 5'd0;
         rd_data_q   <= {XLEN{1'b0}};
         rs1_addr_q  <= 5'd0;
         rs2_addr_q  <= 5'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= 5'd0;
         exp_rs1_q   <= {XLEN{1'b0}};
         exp_rs2_q   <= {XLEN{1'b0}};
      end else begin
         wen_q       <= wen_d;
         rd_addr_q   <= rd_addr_d;
         rd_data_q   <= rd_data_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         exp_rs1_q   <= exp_rs1_d;
         exp_rs2_q   <= exp_rs2_d;
      end
   end

   assign o_regfile_rd_wen   = wen_q;
   assign o_regfile_rd_addr  = rd_addr_q;
   assign o_regfile_rd_data  = rd_data_q;
   assign o_regfile_rs1_addr = rs1_addr_q;
   assign o_regfile_rs2_addr = rs2_addr_q;
   assign o_bist_busy        = busy_q;
   assign o_bist_done        = done_q;
   assign o_bist_fail        = fail_q;
   assign o_bist_fail_addr   = fail_addr_q;

endmodule

// File: tb/tb_riscv_regfile_bist.sv
// -----------------------------------------------------------------------------
// tb_riscv_regfile_bist
// Self-checking bench for riscv_regfile_bist with a behavioural register file
// that supports stuck-at-0 / stuck-at-1 bit faults on read. Honors
// REGFILE_BIST_INV_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_riscv_regfile_bist;
   localparam int XLEN = 32;
`ifdef REGFILE_BIST_INV_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int BUSY_LEN = 64 * PASSES;

   logic            clk;
   logic            rstn;
   logic            start;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            wen;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            busy;
   logic            done;
   logic            fail;
   logic [4:0]      fail_addr;

   int tests_run    = 0;
   int tests_failed = 0;

   riscv_regfile_bist #(.XLEN(XLEN)) dut (
      .i_clk              (clk),
      .i_rstn             (rstn),
      .i_bist_start       (start),
      .o_regfile_rd_addr  (rd_addr),
      .o_regfile_rd_data  (rd_data),
      .o_regfile_rd_wen   (wen),
      .o_regfile_rs1_addr (rs1_addr),
      .o_regfile_rs2_addr (rs2_addr),
      .i_regfile_rs1_data (rs1_data),
      .i_regfile_rs2_data (rs2_data),
      .o_bist_busy        (busy),
      .o_bist_done        (done),
      .o_bist_fail        (fail),
      .o_bist_fail_addr   (fail_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file with per-bit read faults
   logic [XLEN-1:0] mem    [32];
   logic [XLEN-1:0] stuck0 [32];
   logic [XLEN-1:0] stuck1 [32];

   always @(posedge clk) begin
      if (wen && rd_addr != 5'd0) mem[rd_addr] <= rd_data;
   end

   always_comb begin
      rs1_data = (((rs1_addr == 5'd0) ? {XLEN{1'b0}} : mem[rs1_addr]) & ~stuck0[rs1_addr]) | stuck1[rs1_addr];
      rs2_data = (((rs2_addr == 5'd0) ? {XLEN{1'b0}} : mem[rs2_addr]) & ~stuck0[rs2_addr]) | stuck1[rs2_addr];
   end

   // Test pattern of register n in pass p
   function automatic logic [XLEN-1:0] pat(input int n, input int p);
      logic [7:0] b;
      b = {3'b101, n[4:0]};
      return (p != 0) ? ~{(XLEN/8){b}} : {(XLEN/8){b}};
   endfunction

   function automatic logic [XLEN-1:0] expv(input int n, input int p);
      return (n == 0) ? {XLEN{1'b0}} : pat(n, p);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < 32; i++) begin
         stuck0[i] = {XLEN{1'b0}};
         stuck1[i] = {XLEN{1'b0}};
      end
   endtask

   task automatic set_fault(input int r, input int b, input bit one);
      if (r >= 0) begin
         if (one) stuck1[r][b] = 1'b1;
         else     stuck0[r][b] = 1'b1;
      end
   endtask

   // Reference outcome: walk every pass at the level of "write all, read all"
   task automatic predict(output logic f, output logic [4:0] fa);
      logic [XLEN-1:0] val [32];
      logic [XLEN-1:0] v;
      f  = 1'b0;
      fa = 5'd0;
      for (int p = 0; p < PASSES; p++) begin
         for (int n = 0; n < 32; n++) val[n] = pat(n, p);
         for (int a = 0; a < 32; a++) begin
            int m;
            m = 31 - a;
            v = (((a == 0) ? {XLEN{1'b0}} : val[a]) & ~stuck0[a]) | stuck1[a];
            if (!f && v != expv(a, p)) begin
               f = 1'b1; fa = 5'(a);
            end
            v = (((m == 0) ? {XLEN{1'b0}} : val[m]) & ~stuck0[m]) | stuck1[m];
            if (!f && v != expv(m, p)) begin
               f = 1'b1; fa = 5'(m);
            end
         end
      end
   endtask

   // One full BIST run from a start pulse, checking protocol and outcome
   task automatic run_test(input string tag, input logic exp_f, input logic [4:0] exp_fa);
      int k = 1, busy_cnt = 0, done_k = 0, wr_idx = 0, wr_err = 0, rd_idx = 0, rd_err = 0;
      logic [XLEN-1:0] x5_data = {XLEN{1'b0}};
      logic [XLEN-1:0] x1_inv  = {XLEN{1'b0}};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (done_k == 0 && k <= BUSY_LEN + 10) begin
         if (busy) busy_cnt++;
         if (wen) begin
            if (rd_addr != 5'(wr_idx % 32) || rd_data != pat(wr_idx % 32, wr_idx / 32)) wr_err++;
            if (rd_addr == 5'd5 && wr_idx / 32 == 0) x5_data = rd_data;
            if (rd_addr == 5'd1 && wr_idx / 32 == 1) x1_inv = rd_data;
            wr_idx++;
         end else if (busy) begin
            if (rs1_addr != 5'(rd_idx % 32) || rs2_addr != 5'(31 - rd_idx % 32)) rd_err++;
            rd_idx++;
         end
         if (done) done_k = k;
         else begin
            @(negedge clk); k++;
         end
      end
      check({tag, " busy_cycles"}, busy_cnt, BUSY_LEN);
      check({tag, " done_cycle"}, done_k, BUSY_LEN + 1);
      check({tag, " write_count"}, wr_idx, 32 * PASSES);
      check({tag, " write_errs"}, wr_err, 0);
      check({tag, " read_count"}, rd_idx, 32 * PASSES);
      check({tag, " read_addr_errs"}, rd_err, 0);
      check({tag, " x5_data"}, x5_data, 32'hA5A5A5A5);
`ifdef REGFILE_BIST_INV_EN
      check({tag, " x1_inv_data"}, x1_inv, 32'h5E5E5E5E);
`endif
      check({tag, " fail"}, fail, exp_f);
      check({tag, " fail_addr"}, fail_addr, exp_fa);
      check({tag, " idle_ports_at_done"}, {busy, wen, rd_addr, rd_data, rs1_addr, rs2_addr}, 0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, {done, busy}, 0);
      repeat (3) @(negedge clk);
      check({tag, " fail_held"}, {fail, fail_addr}, {exp_f, exp_fa});
   endtask

   typedef struct {
      string      name;
      int         reg_a;
      int         bit_a;
      bit         one_a;
      int         reg_b;
      int         bit_b;
      bit         one_b;
      logic       exp_fail;
      logic [4:0] exp_addr;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic       pf;
      logic [4:0] pfa;
      int         k1, k2, dcnt;
      logic       b_idle, b_restart, b_after;

      vecs[0] = '{"clean",      -1, 0, 1'b0, -1, 0, 1'b0, 1'b0, 5'd0};
      vecs[1] = '{"x7_b0_sa0",   7, 0, 1'b0, -1, 0, 1'b0, 1'b1, 5'd7};
      vecs[2] = '{"x3_x28",      3, 5, 1'b0, 28, 5, 1'b0, 1'b1, 5'd3};
      vecs[3] = '{"x28_only",   28, 5, 1'b0, -1, 0, 1'b0, 1'b1, 5'd28};
      vecs[4] = '{"x0_sa1",      0, 0, 1'b1, -1, 0, 1'b0, 1'b1, 5'd0};
      vecs[5] = '{"x31_b7_sa0", 31, 7, 1'b0, -1, 0, 1'b0, 1'b1, 5'd31};
`ifdef REGFILE_BIST_INV_EN
      vecs[6] = '{"x9_b7_sa1",   9, 7, 1'b1, -1, 0, 1'b0, 1'b1, 5'd9};
`else
      vecs[6] = '{"x9_b7_sa1",   9, 7, 1'b1, -1, 0, 1'b0, 1'b0, 5'd0};
`endif

      rstn  = 1'b0;
      start = 1'b0;
      clear_faults();
      repeat (2) @(negedge clk);
      check("reset_outputs", {busy, done, fail, fail_addr, wen, rd_addr, rd_data, rs1_addr, rs2_addr}, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Table of fault configurations
      for (int i = 0; i < 7; i++) begin
         clear_faults();
         set_fault(vecs[i].reg_a, vecs[i].bit_a, vecs[i].one_a);
         set_fault(vecs[i].reg_b, vecs[i].bit_b, vecs[i].one_b);
         run_test(vecs[i].name, vecs[i].exp_fail, vecs[i].exp_addr);
      end

      // Reset in the middle of a run (fail already set by the x0 fault)
      clear_faults();
      set_fault(0, 0, 1'b1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (39) @(negedge clk);
      check("mid_busy_before_reset", {busy, fail}, 2'b11);
      rstn = 1'b0;
      #1;
      check("mid_reset_outputs", {busy, done, fail, fail_addr, wen, rd_addr, rd_data, rs1_addr, rs2_addr}, 0);
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      rstn = 1'b1;
      repeat (BUSY_LEN + 5) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("mid_reset_no_done", dcnt, 0);
      clear_faults();
      run_test("after_reset", 1'b0, 5'd0);

      // Start held high: back-to-back runs, DONE cycle not accepting start
      k1 = 0; k2 = 0; dcnt = 0; b_idle = 1'b1; b_restart = 1'b0; b_after = 1'b1;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 2 * BUSY_LEN + 6; k++) begin
         @(negedge clk);
         if (k == BUSY_LEN + 10) start = 1'b0;
         if (done) begin
            dcnt++;
            if (k1 == 0) k1 = k; else k2 = k;
         end
         if (k == BUSY_LEN + 2) b_idle = busy;
         if (k == BUSY_LEN + 3) b_restart = busy;
         if (k == 2 * BUSY_LEN + 5) b_after = busy;
      end
      start = 1'b0;
      check("hold_done_count", dcnt, 2);
      check("hold_first_done", k1, BUSY_LEN + 1);
      check("hold_second_done", k2, 2 * BUSY_LEN + 3);
      check("hold_idle_gap", {b_idle, b_restart, b_after}, 3'b010);

      // Randomised fault sets checked against the reference outcome
      for (int i = 0; i < 8; i++) begin
         int nf;
         clear_faults();
         nf = $urandom_range(0, 2);
         for (int j = 0; j < nf; j++)
            set_fault($urandom_range(0, 31), $urandom_range(0, XLEN - 1), 1'($urandom_range(0, 1)));
         predict(pf, pfa);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_test($sformatf("rand%0d", i), pf, pfa);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
